// File: rtl/mcpu_pkg.sv
// ============================================================================
// Module   : mcpu_pkg
// Brief    : Shared widths and opcode constants for the mcpu front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcpu_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_BEQ  = 4'h6,
    OP_JMP  = 4'h7,
    OP_NOP  = 4'hF
  } opcode_e;

endpackage

`default_nettype wire

// File: rtl/mcpu_sync_fifo.sv
// ============================================================================
// Module   : mcpu_sync_fifo
// Brief    : Power-of-two synchronous FIFO with flush; storage is not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // Guards keep the FIFO self-consistent even if a caller misbehaves.
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count < c_depth) | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !reset && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mcpu_prefetch_queue.sv
// ============================================================================
// Module   : mcpu_prefetch_queue
// Brief    : Instruction prefetch queue: fetch PC, redirect flush, head output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_prefetch_queue #(
  parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [ADDR_WIDTH-1:0]    instraddr,
  input  logic [WORD_SIZE-1:0]     instrrd,
  output logic                     instr_valid,
  output logic [WORD_SIZE-1:0]     instr,
  output logic [ADDR_WIDTH-1:0]    instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  import mcpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + WORD_SIZE;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]         w_count;
  logic [EW-1:0]         w_head;
  logic                  w_pop;
  logic                  w_push;

  assign instr_valid = (w_count != '0);
  assign w_pop  = instr_valid & instr_ready & ~redirect;
  assign w_push = fetch_en & ~redirect & ((w_count < c_depth) | w_pop);

  always_ff @(posedge clk) begin
    if (reset)         r_fetch_pc <= '0;
    else if (redirect) r_fetch_pc <= redirect_pc;
    else if (w_push)   r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
  end

  // Each entry carries the fetch address alongside the word for instr_pc.
  mcpu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({r_fetch_pc, instrrd}),
    .dout  (w_head),
    .count (w_count)
  );

  assign instraddr = r_fetch_pc;
  assign instr     = w_head[WORD_SIZE-1:0];
  assign instr_pc  = w_head[EW-1:WORD_SIZE];
  assign count     = w_count;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_prefetch_queue.sv
// ============================================================================
// Module   : tb_mcpu_prefetch_queue
// Brief    : Directed vector bench for the prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [7:0]  instraddr;
  logic [15:0] instrrd;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  mcpu_prefetch_queue #(.WORD_SIZE(16), .ADDR_WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .instraddr   (instraddr),
    .instrrd     (instrrd),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count)
  );

  // Instruction memory: word at address a is 0x1000 + a.
  assign instrrd = 16'h1000 + {8'h00, instraddr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       fe;
    logic       rdy;
    logic       rd;
    logic [7:0] rpc;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] ea;
    logic [7:0] epc;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic fe, input logic rdy,
                      input logic rd, input logic [7:0] rpc);
    @(negedge clk);
    reset = rst; fetch_en = fe; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] held_pc;
    logic [15:0] held_instr;
    int waited;

    reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    //           rst   fe    rdy   rd    rpc     ev    ec    ea      epc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 8'h01, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h02, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 8'h03, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 8'h04, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 8'h04, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 8'h05, 8'h01};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 8'h06, 8'h02};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 8'h07, 8'h03};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 8'h08, 8'h04};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 3'd0, 8'h40, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 8'h41, 8'h40};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h01, 8'h00};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 3'd0, 8'hFE, 8'h00};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'hFF, 8'hFE};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h00, 8'hFF};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h01, 8'h00};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h02, 8'h01};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h02, 8'h00};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h02, 8'h00};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 8'h03, 8'h02};

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
      check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].ec});
      check($sformatf("v%0d_addr", i), {24'd0, instraddr}, {24'd0, vecs[i].ea});
      if (vecs[i].ev) begin
        check($sformatf("v%0d_pc", i), {24'd0, instr_pc}, {24'd0, vecs[i].epc});
        check($sformatf("v%0d_instr", i), {16'd0, instr}, {16'h0000, 8'h10, vecs[i].epc});
      end
    end

    // Partially full queue: simultaneous push and pop holds count at 2.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("fill2_count", {29'd0, count}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      check($sformatf("pp%0d_count", k), {29'd0, count}, 32'd2);
      check($sformatf("pp%0d_pc", k), {24'd0, instr_pc}, k + 1);
    end

    // Head must hold steady with no pop and no fetch.
    held_pc = instr_pc;
    held_instr = instr;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("hold%0d_pc", k), {24'd0, instr_pc}, {24'd0, held_pc});
      check($sformatf("hold%0d_instr", k), {16'd0, instr}, {16'd0, held_instr});
    end

    // From empty, the first valid must appear exactly one edge after fetch_en rises.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b0;
    waited = 0;
    while (!instr_valid && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("first_valid_latency", waited, 32'd1);
    check("first_valid_pc", {24'd0, instr_pc}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
